retire_stage: RTL

- In-order commit stage directly downstream of the ROB.
- Each cycle it inspects the up-to-N oldest ROB entries and computes how many retire (num_retiring back to the ROB).
- Frees the stale physical registers (T_old) to the free list and updates the architectural map table.
- Tracks the retired-instruction count and halt state; the driver/testbench uses these to end simulation.

---
 rtl/retire_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/retire_stage.sv
// ============================================================================
// Module   : retire_stage
// Purpose  : In-order commit stage behind the ROB. It retires the oldest
//            complete prefix, frees the stale physical registers and updates
//            the committed architectural map. The optional retire trace is
//            enabled by defining RETIRE_TRACE_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef N
`define N 2
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif

package retire_pkg;
    localparam int ROB_ARCH_BITS = 5;
    localparam int ROB_PHYS_BITS = 6;

    typedef struct packed {
        logic                     complete;
        logic                     has_dest;
        logic [ROB_ARCH_BITS-1:0] dest_reg_idx;
        logic [ROB_PHYS_BITS-1:0] T_new;
        logic [ROB_PHYS_BITS-1:0] T_old;
        logic                     halt;
    } ROB_PACKET;
endpackage

module retire_stage
    import retire_pkg::*;
#(
    parameter int ARCH_REGS = 32,
    parameter int ARCH_BITS = 5,
    parameter int PHYS_BITS = 6,
    parameter int CNT_BITS  = 64
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  ROB_PACKET                             rob_outputs [`N],
    input  logic [`NUM_SCALAR_BITS-1:0]           rob_outputs_valid,
    output logic [`NUM_SCALAR_BITS-1:0]           num_retiring,
    output logic [`N-1:0]                         free_valid,
    output logic [`N-1:0][PHYS_BITS-1:0]          free_reg,
    output logic [ARCH_REGS-1:0][PHYS_BITS-1:0]   arch_map,
`ifdef RETIRE_TRACE_EN
    output logic [`N-1:0]                         trace_valid,
    output logic [`N-1:0][ARCH_BITS-1:0]          trace_dest,
    output logic [`N-1:0][PHYS_BITS-1:0]          trace_preg,
`endif
    output logic [CNT_BITS-1:0]                   retired_count,
    output logic                                  halted
);

    localparam int NL  = `N;
    localparam int NSB = `NUM_SCALAR_BITS;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                              state_q;
    logic [ARCH_REGS-1:0][PHYS_BITS-1:0] map_q, map_d;
    logic [CNT_BITS-1:0]                 count_q;
    logic [NSB-1:0]                      n_retire;
    logic [NL-1:0]                       lane_ret;
    logic                                halt_ret;

    // Oldest-first prefix: stops at the first incomplete lane, and just after a halt.
    always_comb begin
        logic stop;
        stop     = 1'b0;
        n_retire = '0;
        lane_ret = '0;
        halt_ret = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (!stop && (NSB'(i) < rob_outputs_valid) && rob_outputs[i].complete
                && (state_q == RUN)) begin
                n_retire    = NSB'(i + 1);
                lane_ret[i] = 1'b1;
                if (rob_outputs[i].halt) begin
                    halt_ret = 1'b1;
                    stop     = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_comb begin
        free_valid = '0;
        free_reg   = '0;
        map_d      = map_q;
        for (int i = 0; i < NL; i++) begin
            if (lane_ret[i] && rob_outputs[i].has_dest && (rob_outputs[i].dest_reg_idx != '0)) begin
                free_valid[i]                      = 1'b1;
                free_reg[i]                        = rob_outputs[i].T_old;
                map_d[rob_outputs[i].dest_reg_idx] = rob_outputs[i].T_new;
            end
        end
        map_d[0] = '0;
    end

`ifdef RETIRE_TRACE_EN
    logic [NL-1:0]                trace_valid_q;
    logic [NL-1:0][ARCH_BITS-1:0] trace_dest_q;
    logic [NL-1:0][PHYS_BITS-1:0] trace_preg_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            count_q <= '0;
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= PHYS_BITS'(i);
            end
`ifdef RETIRE_TRACE_EN
            trace_valid_q <= '0;
            trace_dest_q  <= '0;
            trace_preg_q  <= '0;
`endif
        end else begin
            map_q   <= map_d;
            count_q <= count_q + CNT_BITS'(n_retire);
            if (halt_ret) begin
                state_q <= HALTED;
            end
`ifdef RETIRE_TRACE_EN
            for (int i = 0; i < NL; i++) begin
                trace_valid_q[i] <= lane_ret[i] && rob_outputs[i].has_dest;
                trace_dest_q[i]  <= lane_ret[i] ? rob_outputs[i].dest_reg_idx : '0;
                trace_preg_q[i]  <= lane_ret[i] ? rob_outputs[i].T_new : '0;
            end
`endif
        end
    end

    assign num_retiring  = n_retire;
    assign arch_map      = map_q;
    assign retired_count = count_q;
    assign halted        = (state_q == HALTED);

`ifdef RETIRE_TRACE_EN
    assign trace_valid = trace_valid_q;
    assign trace_dest  = trace_dest_q;
    assign trace_preg  = trace_preg_q;
`endif

endmodule

`default_nettype wire
